// File: rtl/except_resolve.sv
// Floating-point exception resolution: classifies each result bundle, substitutes
// special values per IEEE-754 rules and maintains sticky exception flags.
module except_resolve #(
    parameter logic [31:0] QNAN_CANON = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic        opa_nan,
    input  logic        opb_nan,
    input  logic        snan,
    input  logic        opa_inf,
    input  logic        opb_inf,
    input  logic        opa_00,
    input  logic        opb_00,
    input  logic [31:0] res,
    input  logic        ovf_raw,
    input  logic        unf_raw,
    input  logic        inx_raw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags,
    output logic [4:0]  sticky_flags,
    input  logic        clr_sticky
);

    typedef enum logic [2:0] {
        C_NAN, C_INVALID, C_DIVZ, C_DIVINF, C_INF, C_OVF, C_NORM
    } case_t;

    logic        s1_valid;
    case_t       s1_case;
    logic        s1_sign;
    logic        s1_snan;
    logic [31:0] s1_res;
    logic        s1_unf;
    logic        s1_inx;

    case_t       dec_case;
    logic        dec_sign;
    logic        eff_sub;
    logic        inv_op;
    logic        s1_en;
    logic        s2_en;
    logic        out_xfer;
    logic [31:0] nxt_result;
    logic [4:0]  nxt_flags;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        eff_sub  = (op == 2'b00 && sign_a != sign_b) || (op == 2'b01 && sign_a == sign_b);
        inv_op   = (!op[1] && opa_inf && opb_inf && eff_sub)
                || (op == 2'b10 && ((opa_inf && opb_00) || (opa_00 && opb_inf)))
                || (op == 2'b11 && ((opa_00 && opb_00) || (opa_inf && opb_inf)));
        dec_case = C_NORM;
        dec_sign = sign_a ^ sign_b;
        if (opa_nan || opb_nan) begin
            dec_case = C_NAN;
        end else if (inv_op) begin
            dec_case = C_INVALID;
        end else if (op == 2'b11 && opb_00 && !opa_00) begin
            dec_case = C_DIVZ;
        end else if (op == 2'b11 && opb_inf) begin
            dec_case = C_DIVINF;
        end else if (opa_inf || opb_inf) begin
            dec_case = C_INF;
            // add/sub: infinite operand's sign; subtracting an infinite b flips it
            if (!op[1]) dec_sign = opa_inf ? sign_a : (sign_b ^ op[0]);
        end else if (ovf_raw) begin
            dec_case = C_OVF;
        end
    end

    always_comb begin
        nxt_result = s1_res;
        nxt_flags  = {3'b000, s1_unf && s1_inx, s1_inx};
        case (s1_case)
            C_NAN: begin
                nxt_result = QNAN_CANON;
                nxt_flags  = {s1_snan, 4'b0000};
            end
            C_INVALID: begin
                nxt_result = QNAN_CANON;
                nxt_flags  = 5'b10000;
            end
            C_DIVZ: begin
                nxt_result = {s1_sign, 8'hFF, 23'h0};
                nxt_flags  = 5'b01000;
            end
            C_DIVINF: begin
                nxt_result = {s1_sign, 31'h0};
                nxt_flags  = '0;
            end
            C_INF: begin
                nxt_result = {s1_sign, 8'hFF, 23'h0};
                nxt_flags  = '0;
            end
            C_OVF: begin
                nxt_result = {s1_res[31], 8'hFF, 23'h0};
                nxt_flags  = 5'b00101;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_case      <= C_NORM;
            s1_sign      <= 1'b0;
            s1_snan      <= 1'b0;
            s1_res       <= '0;
            s1_unf       <= 1'b0;
            s1_inx       <= 1'b0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_flags    <= '0;
            sticky_flags <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_case <= dec_case;
                    s1_sign <= dec_sign;
                    s1_snan <= snan;
                    s1_res  <= res;
                    s1_unf  <= unf_raw;
                    s1_inx  <= inx_raw;
                end
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= nxt_result;
                    out_flags  <= nxt_flags;
                end
            end
            if (clr_sticky) begin
                sticky_flags <= out_xfer ? out_flags : '0;
            end else if (out_xfer) begin
                sticky_flags <= sticky_flags | out_flags;
            end
        end
    end

endmodule

// File: tb/tb_except_resolve.sv
// Directed self-checking bench for except_resolve: special-case resolution,
// sticky flag behaviour, backpressure stall and reset flush.
module tb_except_resolve;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        sign_a, sign_b;
    logic        opa_nan, opb_nan, snan, opa_inf, opb_inf, opa_00, opb_00;
    logic [31:0] res;
    logic        ovf_raw, unf_raw, inx_raw;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  sticky_flags;
    logic        clr_sticky;

    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];

    except_resolve #(.QNAN_CANON(32'h7FC00000)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sign_a(sign_a), .sign_b(sign_b),
        .opa_nan(opa_nan), .opb_nan(opb_nan), .snan(snan),
        .opa_inf(opa_inf), .opb_inf(opb_inf), .opa_00(opa_00), .opb_00(opb_00),
        .res(res), .ovf_raw(ovf_raw), .unf_raw(unf_raw), .inx_raw(inx_raw),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .sticky_flags(sticky_flags), .clr_sticky(clr_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every completed output transfer
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) q.push_back(out_result);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cls = {opa_nan, opb_nan, snan, opa_inf, opb_inf, opa_00, opb_00}; raw = {ovf, unf, inx}
    task automatic set_in(input logic [1:0] o, input logic sa, input logic sb,
                          input logic [6:0] cls, input logic [31:0] r, input logic [2:0] raw);
        op = o;
        sign_a = sa;
        sign_b = sb;
        {opa_nan, opb_nan, snan, opa_inf, opb_inf, opa_00, opb_00} = cls;
        res = r;
        {ovf_raw, unf_raw, inx_raw} = raw;
    endtask

    task automatic single(input string tag, input logic [1:0] o, input logic sa, input logic sb,
                          input logic [6:0] cls, input logic [31:0] r, input logic [2:0] raw,
                          input logic [31:0] exp_res, input logic [4:0] exp_flags);
        set_in(o, sa, sb, cls, r, raw);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_bubble"}, 32'(out_valid), 0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_result"}, out_result, exp_res);
        check({tag, "_flags"}, 32'(out_flags), 32'(exp_flags));
    endtask

    task automatic clear_sticky();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_clr", 32'(sticky_flags), 0);
    endtask

    task automatic push(input logic [31:0] r);
        logic acc;
        set_in(2'b00, 1'b0, 1'b0, 7'b0, r, 3'b000);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        check("push_accept", 32'(acc), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_sticky = 1'b0;
        set_in(2'b00, 1'b0, 1'b0, 7'b0, 32'h0, 3'b000);
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_flags", 32'(out_flags), 0);
        check("rst_sticky", 32'(sticky_flags), 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 1);

        single("add_inf_inf", 2'b00, 1'b0, 1'b1, 7'b0001100, 32'h0, 3'b000, 32'h7FC00000, 5'b10000);
        step();
        check("sticky_inv", 32'(sticky_flags), 32'h10);
        clear_sticky();

        single("div_zero", 2'b11, 1'b1, 1'b0, 7'b0000001, 32'h0, 3'b000, 32'hFF800000, 5'b01000);
        step();
        check("sticky_divz", 32'(sticky_flags), 32'h08);
        clear_sticky();

        single("mul_ovf", 2'b10, 1'b0, 1'b0, 7'b0, 32'h7F800000, 3'b100, 32'h7F800000, 5'b00101);
        step();
        single("mul_unf", 2'b10, 1'b0, 1'b0, 7'b0, 32'h00000001, 3'b011, 32'h00000001, 5'b00011);
        step();
        check("sticky_ovf_unf", 32'(sticky_flags), 32'h07);

        single("qnan", 2'b00, 1'b0, 1'b0, 7'b1000000, 32'h12345678, 3'b000, 32'h7FC00000, 5'b00000);
        step();
        single("snan_div0", 2'b11, 1'b0, 1'b0, 7'b0110001, 32'h0, 3'b000, 32'h7FC00000, 5'b10000);
        step();
        single("div_by_inf", 2'b11, 1'b0, 1'b1, 7'b0000100, 32'h0, 3'b000, 32'h80000000, 5'b00000);
        step();
        single("sub_b_inf", 2'b01, 1'b0, 1'b0, 7'b0000100, 32'h0, 3'b000, 32'hFF800000, 5'b00000);
        step();
        single("add_a_inf", 2'b00, 1'b0, 1'b1, 7'b0001000, 32'h0, 3'b000, 32'h7F800000, 5'b00000);
        step();
        single("add_neg_infs", 2'b00, 1'b1, 1'b1, 7'b0001100, 32'h0, 3'b000, 32'hFF800000, 5'b00000);
        step();
        single("sub_inf_inf", 2'b01, 1'b0, 1'b0, 7'b0001100, 32'h0, 3'b000, 32'h7FC00000, 5'b10000);
        step();
        single("mul_inf_zero", 2'b10, 1'b0, 1'b0, 7'b0001001, 32'h0, 3'b000, 32'h7FC00000, 5'b10000);
        step();
        single("div_zero_zero", 2'b11, 1'b0, 1'b0, 7'b0000011, 32'h0, 3'b000, 32'h7FC00000, 5'b10000);
        step();
        single("mul_inf_sign", 2'b10, 1'b1, 1'b0, 7'b0001000, 32'h0, 3'b000, 32'hFF800000, 5'b00000);
        step();
        single("norm_inexact", 2'b00, 1'b0, 1'b0, 7'b0, 32'h3F800000, 3'b001, 32'h3F800000, 5'b00001);
        step();
        single("tiny_exact", 2'b00, 1'b0, 1'b0, 7'b0, 32'h00000010, 3'b010, 32'h00000010, 5'b00000);
        step();
        single("ovf_neg", 2'b00, 1'b0, 1'b0, 7'b0, 32'hFF7FFFFF, 3'b101, 32'hFF800000, 5'b00101);
        step();
        clear_sticky();

        // Four back-to-back bundles with a 3-cycle downstream stall
        q.delete();
        fork
            begin
                push(32'd1);
                push(32'd2);
                push(32'd3);
                push(32'd4);
                in_valid = 1'b0;
            end
            begin
                step();
                step();
                out_ready = 1'b0;
                #1;
                check("stall_in_ready", 32'(in_ready), 0);
                check("stall_valid", 32'(out_valid), 1);
                check("stall_result", out_result, 1);
                for (int i = 0; i < 3; i++) begin
                    step();
                    check("stall_hold_valid", 32'(out_valid), 1);
                    check("stall_hold_result", out_result, 1);
                    check("stall_hold_in_ready", 32'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 30 && q.size() < 4; i++) step();
        repeat (3) step();
        check("stream_count", 32'(q.size()), 4);
        for (int i = 0; i < 4 && i < q.size(); i++) check("stream_order", q[i], 32'(i + 1));

        single("pre_snan", 2'b00, 1'b0, 1'b0, 7'b0110000, 32'h0, 3'b000, 32'h7FC00000, 5'b10000);
        step();
        check("sticky_pre_clr", 32'(sticky_flags), 32'h10);
        single("clr_divz", 2'b11, 1'b0, 1'b0, 7'b0000001, 32'h0, 3'b000, 32'h7F800000, 5'b01000);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_clr_xfer", 32'(sticky_flags), 32'h08);

        // Reset with two bundles in flight
        out_ready = 1'b0;
        set_in(2'b00, 1'b0, 1'b0, 7'b0, 32'h0000AAAA, 3'b001);
        in_valid = 1'b1;
        step();
        res = 32'h0000BBBB;
        step();
        in_valid = 1'b0;
        check("flight_valid", 32'(out_valid), 1);
        n = q.size();
        rst_n = 1'b0;
        step();
        check("flush_valid", 32'(out_valid), 0);
        check("flush_result", out_result, 0);
        check("flush_flags", 32'(out_flags), 0);
        check("flush_sticky", 32'(sticky_flags), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();
        check("flush_no_valid", 32'(out_valid), 0);
        check("flush_no_xfer", 32'(q.size()), 32'(n));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
